// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
// Shared definitions for the round-robin mux arbiter slice: the state
// encoding, the number of sources, the source-index width and the default
// burst length a single grant may hold the channel for.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int NSRC             = 4;
  localparam int IDXW             = 2;
  localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/mux_rr_arbiter_mux2.sv
// mux_rr_arbiter_mux2
// Plain W-bit 2:1 multiplexer, the leaf cell of the arbiter's data mux tree.
// Ports:
//   sel : 0 selects a, 1 selects b
//   a,b : data inputs
//   y   : selected data
module mux_rr_arbiter_mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick
// Combinational rotating-priority selector. Scans req starting at ptr and
// wrapping modulo NSRC, returning the first requester found.
// Ports:
//   req : request vector, bit i = source i
//   ptr : index that has highest priority this time
//   any : at least one request is set
//   idx : chosen source index (0 when any is low)
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] cand;

  // Walk the offsets from farthest to nearest so the closest requester
  // to ptr is the last one written and therefore wins.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      cand = ptr + IDXW'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Shares one W-bit output channel between four requesters. A grant is held
// for up to MAX_HOLD accepted beats (or until the granted source drops its
// request), then the pointer moves past the granted source so the next
// grant is decided round-robin. The output data comes from a 4:1 mux tree
// of 2:1 cells steered by the granted index.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   req       : per-source request
//   din       : source data, source i in din[i*W +: W]
//   gnt       : registered one-hot grant, zero when idle
//   out_valid : beat valid (granted source still requesting)
//   out_ready : consumer accepts the beat
//   out_data  : data of the granted source
//   out_src   : index of the granted source
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int W        = 32,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   req,
  input  logic [NSRC*W-1:0] din,
  output logic [NSRC-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [IDXW-1:0]   out_src
);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] g_q, g_d;
  logic [7:0]      holdCnt_q, holdCnt_d;
  logic [NSRC-1:0] gnt_q, gnt_d;

  logic            pickAny;
  logic [IDXW-1:0] pickIdx;
  logic            transfer;
  logic            lastBeat;
  logic [W-1:0]    muxLo, muxHi;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pickAny),
    .idx (pickIdx)
  );

  // g[0] picks within each pair, g[1] picks between the pairs.
  mux_rr_arbiter_mux2 #(.W(W)) u_muxLo (
    .sel (g_q[0]),
    .a   (din[0*W +: W]),
    .b   (din[1*W +: W]),
    .y   (muxLo)
  );

  mux_rr_arbiter_mux2 #(.W(W)) u_muxHi (
    .sel (g_q[0]),
    .a   (din[2*W +: W]),
    .b   (din[3*W +: W]),
    .y   (muxHi)
  );

  mux_rr_arbiter_mux2 #(.W(W)) u_muxTop (
    .sel (g_q[1]),
    .a   (muxLo),
    .b   (muxHi),
    .y   (out_data)
  );

  assign out_valid = (state_q == GRANT) && req[g_q];
  assign transfer  = out_valid && out_ready;
  assign lastBeat  = (holdCnt_q == 8'(MAX_HOLD - 1));
  assign out_src   = g_q;
  assign gnt       = gnt_q;

  // Next-state logic. A dropped request releases immediately with no beat,
  // so the release test does not need transfer for that case.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    holdCnt_d = holdCnt_q;
    gnt_d     = gnt_q;
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          state_d   = GRANT;
          g_d       = pickIdx;
          gnt_d     = NSRC'(1) << pickIdx;
          holdCnt_d = '0;
        end
      end
      GRANT: begin
        if (!req[g_q] || (transfer && lastBeat)) begin
          state_d   = IDLE;
          ptr_d     = g_q + IDXW'(1);
          gnt_d     = '0;
          holdCnt_d = '0;
        end else if (transfer) begin
          holdCnt_d = holdCnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-burst discards
  // the beat in flight and returns the pointer to source 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      holdCnt_q <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      holdCnt_q <= holdCnt_d;
      gnt_q     <= gnt_d;
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one W-bit output channel between four requesters by sequencing the select of a 4:1 data mux tree. It sits in front of a shared datapath resource (ALU operand port, register-file write port) and turns four independent request lines into one valid/ready stream. Each grant is tagged with the source index. A grant is held for a burst of up to MAX_HOLD transfers, then passed round-robin.

## Interface
- W, default 32: data width of each source and of the output.
- MAX_HOLD, default 8: maximum transfers per grant, range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  in  4  request per source; bit i = source i.
- din  in  4*W  source data; source i occupies bits [i*W +: W].
- gnt  out  4  one-hot grant (all zero when idle); registered.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  W  data of the granted source.
- out_src  out  2  index of the granted source.

## Operation
- Two states:
  - IDLE: gnt=0.
  - GRANT: gnt one-hot, register g holds the granted index.
- IDLE:
  - If req≠0, pick the first set bit scanning ptr, ptr+1, … mod 4.
  - At the edge, load g and gnt, clear hold_cnt, enter GRANT.
  - If req=0, stay in IDLE.
- GRANT outputs:
  - out_valid = req[g].
  - out_data = din slice g, via the mux tree (combinational).
  - out_src = g.
- Transfer: any cycle with out_valid && out_ready. A transfer increments hold_cnt (8 bits).
- Release from GRANT to IDLE at the edge when either holds:
  - req[g]=0 (source withdrew), or
  - a transfer occurs with hold_cnt = MAX_HOLD−1.
- On release: ptr ← (g+1) mod 4, gnt ← 0, hold_cnt ← 0.
- out_ready low while in GRANT: grant held, hold_cnt unchanged. There is no timeout.
- req[j] for j≠g has no effect during GRANT.
- out_data and out_src are don't-care while out_valid=0; a bench must not check them then.
- Reset values:
  - state=IDLE, ptr=0, g=0, hold_cnt=0, gnt=0.
  - out_valid=0, out_src=0, out_data=din slice 0.

## Timing
- Grant latency: req sampled high at edge t in IDLE → gnt and out_valid high after edge t (1 cycle).
- Release costs one IDLE cycle: the last transfer is at edge t, state=IDLE during cycle t+1, next grant is visible after edge t+1.
- Peak throughput: MAX_HOLD beats per MAX_HOLD+1 cycles under continuous requests.
- Simultaneous requests in IDLE are resolved strictly by ptr; there is no fixed priority.
- Withdraw and ready in the same cycle: if req[g] drops while out_ready=1, no transfer occurs (out_valid=0) and the grant is released at that edge.
- MAX_HOLD=1: every transfer releases the grant.
- Reset mid-burst (rst_n low at any edge): all state returns to reset values at that edge. The beat in flight is not counted, and ptr returns to 0.
- hold_cnt never exceeds MAX_HOLD−1; no wrap-around.

## Structure
- Shared package/header holds:
  - state encodings IDLE=1'b0, GRANT=1'b1;
  - source count NSRC=4 and index width 2;
  - the default MAX_HOLD.
- One sub-module, rr_pick: combinational rotating-priority select.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - Verified standalone over all 64 input combinations.
- The data path is a 4:1 mux tree built from the existing 2:1 W-bit mux blocks, selected by g.

## Test plan
- Reset: hold rst_n=0 for 2 edges with req=4'b1111 → gnt=0 and out_valid=0 throughout. After release of reset, the first grant is gnt=4'b0001, out_src=0.
- Fairness: MAX_HOLD=2, req=4'b1111 held, out_ready=1 → grant order 0,1,2,3,0.
  - Each grant gives exactly 2 transfers followed by 1 idle cycle.
  - out_data equals din slice of out_src on every transfer.
- Backpressure: source 2 only, din2=32'hA5A5_0002, out_ready low for 5 cycles then high.
  - gnt=4'b0100 held for all 5 cycles with hold_cnt unchanged.
  - Then MAX_HOLD transfers, all with out_data=32'hA5A5_0002.
- Withdraw: source 1 granted, 3 transfers, then req[1] drops while out_ready=1.
  - No 4th transfer.
  - IDLE on the next cycle, then ptr=2: with req=4'b1011, the next grant is source 3.
- Reset mid-burst: source 3 granted, 2 transfers done, rst_n=0 for one edge.
  - Next cycle gnt=0 and out_valid=0.
  - With req=4'b1001 afterwards, the grant goes to source 0 (ptr=0).
- Pointer wrap: MAX_HOLD=1, req=4'b1001 → grants alternate 0,3,0,3, separated by one IDLE cycle each.
